// File: rtl/tcp_misc_pkg.sv
// Shared constants and helpers for the TCP engine's memory-side plumbing.
// Holds the arbitration mode encodings and the source-index (tag) width helper.
package tcp_misc_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Width of a source index; a single source still needs one bit of storage.
  function automatic int tag_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// N-way arbiter: one-hot grant from a valid vector, fixed priority or round robin.
// In round-robin mode the pointer moves to the granted index only when advance is high.
module rr_arbiter_n
  import tcp_misc_pkg::*;
#(
  parameter int NUM_SRC  = 2,
  parameter int ARB_MODE = ARB_FIXED
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_SRC-1:0]          req,
  input  logic                        advance,
  output logic [NUM_SRC-1:0]          grant,
  output logic [tag_w(NUM_SRC)-1:0]   grant_idx
);

  localparam int IDX_W = tag_w(NUM_SRC);

  logic [IDX_W-1:0] ptr_q;
  logic             found;

  // Two passes: first the indices above the pointer, then wrap to the bottom.
  // With fixed priority the first pass already covers every index.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int j = 0; j < NUM_SRC; j++) begin
      if (!found && req[j] && (ARB_MODE == ARB_FIXED || j > int'(ptr_q))) begin
        grant[j]  = 1'b1;
        grant_idx = IDX_W'(j);
        found     = 1'b1;
      end
    end
    for (int j = 0; j < NUM_SRC; j++) begin
      if (!found && req[j]) begin
        grant[j]  = 1'b1;
        grant_idx = IDX_W'(j);
        found     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= IDX_W'(NUM_SRC - 1);
    end else if (advance && found && ARB_MODE == ARB_RR) begin
      ptr_q <= grant_idx;
    end
  end

endmodule

// File: rtl/mem_rd_mux_n.sv
// N-source memory read-port mux: arbitrates read requests onto one memory port
// and steers in-order responses back using a FIFO of winning source indices.
module mem_rd_mux_n
  import tcp_misc_pkg::*;
#(
  parameter int NUM_SRC         = 2,
  parameter int ADDR_W          = 8,
  parameter int DATA_W          = 64,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ARB_MODE        = ARB_FIXED
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_SRC-1:0]                src_rd_req_val,
  input  logic [NUM_SRC*ADDR_W-1:0]         src_rd_req_addr,
  output logic [NUM_SRC-1:0]                src_rd_req_rdy,
  output logic [NUM_SRC-1:0]                src_rd_resp_val,
  output logic [DATA_W-1:0]                 src_rd_resp_data,
  input  logic [NUM_SRC-1:0]                src_rd_resp_rdy,
  output logic                              dst_rd_req_val,
  output logic [ADDR_W-1:0]                 dst_rd_req_addr,
  input  logic                              dst_rd_req_rdy,
  input  logic                              dst_rd_resp_val,
  input  logic [DATA_W-1:0]                 dst_rd_resp_data,
  output logic                              dst_rd_resp_rdy,
  output logic [$clog2(MAX_OUTSTANDING):0]  outstanding_cnt,
  output logic                              err_orphan_resp
);

  // Every channel uses valid/ready: a beat transfers on the cycle both are high;
  // the sender holds payload stable while valid is high and ready is low.

  localparam int IDX_W = tag_w(NUM_SRC);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING) + 1;

  logic [IDX_W-1:0]   tag_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               empty;
  logic               full;
  logic [NUM_SRC-1:0] arb_req;
  logic [NUM_SRC-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   head_tag;
  logic               head_rdy;
  logic               push;
  logic               pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                 (wr_ptr[PTR_W-2:0] == rd_ptr[PTR_W-2:0]);

  assign arb_req = full ? '0 : src_rd_req_val;

  rr_arbiter_n #(
    .NUM_SRC  (NUM_SRC),
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (arb_req),
    .advance   (dst_rd_req_rdy),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign dst_rd_req_val = |grant;
  assign src_rd_req_rdy = grant & {NUM_SRC{dst_rd_req_rdy}};
  assign push           = dst_rd_req_val & dst_rd_req_rdy;

  always_comb begin
    dst_rd_req_addr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) dst_rd_req_addr = src_rd_req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  assign head_tag = tag_mem[rd_ptr[PTR_W-2:0]];

  always_comb begin
    src_rd_resp_val = '0;
    head_rdy        = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (head_tag == IDX_W'(i)) begin
        src_rd_resp_val[i] = dst_rd_resp_val & ~empty;
        head_rdy           = src_rd_resp_rdy[i];
      end
    end
  end

  assign src_rd_resp_data = dst_rd_resp_data;
  assign dst_rd_resp_rdy  = ~empty & head_rdy;
  assign pop              = dst_rd_resp_val & dst_rd_resp_rdy;
  assign outstanding_cnt  = wr_ptr - rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      err_orphan_resp <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (dst_rd_resp_val && empty) err_orphan_resp <= 1'b1;
    end
  end

  // Tag storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr[PTR_W-2:0]] <= grant_idx;
  end

endmodule

// File: tb/tb_mem_rd_mux_n.sv
// Bench for mem_rd_mux_n: one fixed-priority and one round-robin instance (3 sources),
// checked by a queue-based reference model, a vector table and directed sequences.
module tb_mem_rd_mux_n;

  localparam int N    = 3;
  localparam int AW   = 8;
  localparam int DW   = 64;
  localparam int MAXO = 4;

  logic clk;
  logic rst_n;

  logic [N-1:0]    req_val   [2];
  logic [N*AW-1:0] req_addr  [2];
  logic [N-1:0]    req_rdy   [2];
  logic [N-1:0]    resp_val  [2];
  logic [DW-1:0]   resp_data [2];
  logic [N-1:0]    resp_rdy  [2];
  logic            dreq_val  [2];
  logic [AW-1:0]   dreq_addr [2];
  logic            dreq_rdy  [2];
  logic            dresp_val [2];
  logic [DW-1:0]   dresp_data[2];
  logic            dresp_rdy [2];
  logic [2:0]      ocnt      [2];
  logic            err       [2];

  mem_rd_mux_n #(.NUM_SRC(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MAXO), .ARB_MODE(0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .src_rd_req_val(req_val[0]), .src_rd_req_addr(req_addr[0]), .src_rd_req_rdy(req_rdy[0]),
    .src_rd_resp_val(resp_val[0]), .src_rd_resp_data(resp_data[0]), .src_rd_resp_rdy(resp_rdy[0]),
    .dst_rd_req_val(dreq_val[0]), .dst_rd_req_addr(dreq_addr[0]), .dst_rd_req_rdy(dreq_rdy[0]),
    .dst_rd_resp_val(dresp_val[0]), .dst_rd_resp_data(dresp_data[0]), .dst_rd_resp_rdy(dresp_rdy[0]),
    .outstanding_cnt(ocnt[0]), .err_orphan_resp(err[0])
  );

  mem_rd_mux_n #(.NUM_SRC(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MAXO), .ARB_MODE(1)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .src_rd_req_val(req_val[1]), .src_rd_req_addr(req_addr[1]), .src_rd_req_rdy(req_rdy[1]),
    .src_rd_resp_val(resp_val[1]), .src_rd_resp_data(resp_data[1]), .src_rd_resp_rdy(resp_rdy[1]),
    .dst_rd_req_val(dreq_val[1]), .dst_rd_req_addr(dreq_addr[1]), .dst_rd_req_rdy(dreq_rdy[1]),
    .dst_rd_resp_val(dresp_val[1]), .dst_rd_resp_data(dresp_data[1]), .dst_rd_resp_rdy(dresp_rdy[1]),
    .outstanding_cnt(ocnt[1]), .err_orphan_resp(err[1])
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model / scoreboard ----------------
  logic [1:0] exp_q [2][$];   // source index of each read in flight, oldest first
  int         rr_last [2];    // last source granted with an accepted handshake
  logic       m_err [2];
  logic [N-1:0] last_acc [2];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int n = 0; n < 2; n++) begin
      exp_q[n].delete();
      rr_last[n]  = N - 1;
      m_err[n]    = 1'b0;
      last_acc[n] = '0;
    end
  endtask

  // Predict outputs from the request/response rules, compare, then apply the edge.
  task automatic model_check(input int n);
    int sz;
    int gi;
    logic [N-1:0] g;
    logic [N-1:0] er;
    logic [N-1:0] ersp;
    logic         edr;
    sz = exp_q[n].size();
    gi = -1;
    if (sz < MAXO) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (n == 0) ? k : (rr_last[n] + 1 + k) % N;
        if (gi < 0 && ((req_val[n] >> idx) & 3'b1) != 0) gi = idx;
      end
    end
    g = (gi >= 0) ? (3'b001 << gi) : 3'b000;
    er = dreq_rdy[n] ? g : 3'b000;
    chk($sformatf("%0d:dst_rd_req_val", n), 64'(dreq_val[n]), 64'(|g));
    chk($sformatf("%0d:src_rd_req_rdy", n), 64'(req_rdy[n]), 64'(er));
    if (gi >= 0) chk($sformatf("%0d:dst_rd_req_addr", n), 64'(dreq_addr[n]), 64'(8'(req_addr[n] >> (gi * AW))));
    ersp = '0;
    edr  = 1'b0;
    if (sz > 0) begin
      ersp = dresp_val[n] ? (3'b001 << exp_q[n][0]) : 3'b000;
      edr  = ((resp_rdy[n] >> exp_q[n][0]) & 3'b1) != 0;
    end
    chk($sformatf("%0d:src_rd_resp_val", n), 64'(resp_val[n]), 64'(ersp));
    chk($sformatf("%0d:dst_rd_resp_rdy", n), 64'(dresp_rdy[n]), 64'(edr));
    chk($sformatf("%0d:src_rd_resp_data", n), resp_data[n], dresp_data[n]);
    chk($sformatf("%0d:outstanding_cnt", n), 64'(ocnt[n]), 64'(sz));
    chk($sformatf("%0d:err_orphan_resp", n), 64'(err[n]), 64'(m_err[n]));
    if (dresp_val[n] && sz == 0) m_err[n] = 1'b1;
    if (dresp_val[n] && edr) void'(exp_q[n].pop_front());
    if (gi >= 0 && dreq_rdy[n]) begin
      exp_q[n].push_back(2'(gi));
      rr_last[n] = gi;
    end
    last_acc[n] = er;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int n, input logic [N-1:0] v, input logic [N*AW-1:0] a, input logic drdy,
                       input logic rv, input logic [DW-1:0] rd, input logic [N-1:0] rr);
    req_val[n]    = v;
    req_addr[n]   = a;
    dreq_rdy[n]   = drdy;
    dresp_val[n]  = rv;
    dresp_data[n] = rd;
    resp_rdy[n]   = rr;
  endtask

  task automatic idle(input int n);
    drive(n, '0, '0, 1'b1, 1'b0, '0, '1);
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic advance();
    model_check(0);
    model_check(1);
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  // Answer outstanding reads until the instance is empty; bounded by a cycle budget.
  task automatic drain(input int n);
    int budget;
    budget = 20;
    req_val[n]  = '0;
    resp_rdy[n] = '1;
    while (exp_q[n].size() > 0 && budget > 0) begin
      dresp_val[n]  = 1'b1;
      dresp_data[n] = {$urandom, $urandom};
      tick();
      budget--;
    end
    dresp_val[n] = 1'b0;
    chk($sformatf("%0d:drain_budget", n), 64'(exp_q[n].size()), 64'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [N-1:0]    val;
    logic [N*AW-1:0] addr;
    logic            drdy;
    logic            rv;
    logic [DW-1:0]   rd;
    logic [N-1:0]    rr;
    logic [N-1:0]    e_req_rdy;
    logic            e_dreq_val;
    logic [AW-1:0]   e_dreq_addr;
    logic [N-1:0]    e_resp_val;
    logic            e_dresp_rdy;
    logic [2:0]      e_cnt;
  } vec_t;

  vec_t fp_vec [5];
  logic [N-1:0] rr_order [6];

  initial begin
    fp_vec[0] = '{3'b101, 24'h220010, 1'b1, 1'b0, 64'h0,  3'b111, 3'b001, 1'b1, 8'h10, 3'b000, 1'b0, 3'd0};
    fp_vec[1] = '{3'b100, 24'h220010, 1'b1, 1'b0, 64'h0,  3'b111, 3'b100, 1'b1, 8'h22, 3'b000, 1'b1, 3'd1};
    fp_vec[2] = '{3'b000, 24'h000000, 1'b1, 1'b1, 64'hD0, 3'b111, 3'b000, 1'b0, 8'h00, 3'b001, 1'b1, 3'd2};
    fp_vec[3] = '{3'b000, 24'h000000, 1'b1, 1'b1, 64'hD2, 3'b111, 3'b000, 1'b0, 8'h00, 3'b100, 1'b1, 3'd1};
    fp_vec[4] = '{3'b000, 24'h000000, 1'b1, 1'b0, 64'h0,  3'b111, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0, 3'd0};
    rr_order  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    model_clear();
    idle(0);
    idle(1);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int n = 0; n < 2; n++) begin
      chk($sformatf("%0d:reset_cnt", n), 64'(ocnt[n]), 64'd0);
      chk($sformatf("%0d:reset_err", n), 64'(err[n]), 64'd0);
      chk($sformatf("%0d:reset_dreq_val", n), 64'(dreq_val[n]), 64'd0);
      chk($sformatf("%0d:reset_dresp_rdy", n), 64'(dresp_rdy[n]), 64'd0);
      chk($sformatf("%0d:reset_resp_val", n), 64'(resp_val[n]), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fixed priority: src0 then src2, responses routed back in order.
    for (int i = 0; i < 5; i++) begin
      drive(0, fp_vec[i].val, fp_vec[i].addr, fp_vec[i].drdy, fp_vec[i].rv, fp_vec[i].rd, fp_vec[i].rr);
      settle();
      chk($sformatf("vec%0d:req_rdy", i), 64'(req_rdy[0]), 64'(fp_vec[i].e_req_rdy));
      chk($sformatf("vec%0d:dreq_val", i), 64'(dreq_val[0]), 64'(fp_vec[i].e_dreq_val));
      if (fp_vec[i].e_dreq_val) chk($sformatf("vec%0d:dreq_addr", i), 64'(dreq_addr[0]), 64'(fp_vec[i].e_dreq_addr));
      chk($sformatf("vec%0d:resp_val", i), 64'(resp_val[0]), 64'(fp_vec[i].e_resp_val));
      chk($sformatf("vec%0d:dresp_rdy", i), 64'(dresp_rdy[0]), 64'(fp_vec[i].e_dresp_rdy));
      chk($sformatf("vec%0d:cnt", i), 64'(ocnt[0]), 64'(fp_vec[i].e_cnt));
      advance();
    end

    // Response backpressure: head belongs to src1, src0's response waits behind it.
    drive(0, 3'b010, 24'h003100, 1'b1, 1'b0, '0, '1);
    tick();
    drive(0, 3'b001, 24'h000030, 1'b1, 1'b0, '0, '1);
    tick();
    drive(0, 3'b000, '0, 1'b1, 1'b1, 64'hA1, 3'b101);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("bp:dresp_rdy_stalled", 64'(dresp_rdy[0]), 64'd0);
      chk("bp:resp_val_head", 64'(resp_val[0]), 64'(3'b010));
      advance();
    end
    resp_rdy[0] = 3'b111;
    settle();
    chk("bp:dresp_rdy_release", 64'(dresp_rdy[0]), 64'd1);
    advance();
    dresp_data[0] = 64'hA0;
    settle();
    chk("bp:resp_val_src0", 64'(resp_val[0]), 64'(3'b001));
    chk("bp:resp_data_src0", resp_data[0], 64'hA0);
    advance();
    drain(0);

    // Full FIFO: four accepted, then no grant; a pop frees a slot only on the next cycle.
    for (int i = 0; i < MAXO; i++) begin
      drive(0, 3'b001, 24'h000040 + 24'(i), 1'b1, 1'b0, '0, '1);
      tick();
    end
    settle();
    chk("full:cnt", 64'(ocnt[0]), 64'd4);
    chk("full:req_rdy", 64'(req_rdy[0]), 64'd0);
    chk("full:dreq_val", 64'(dreq_val[0]), 64'd0);
    advance();
    dresp_val[0] = 1'b1;
    settle();
    chk("full:pop_no_bypass_rdy", 64'(req_rdy[0]), 64'd0);
    chk("full:pop_dresp_rdy", 64'(dresp_rdy[0]), 64'd1);
    advance();
    dresp_val[0] = 1'b0;
    settle();
    chk("full:slot_freed_rdy", 64'(req_rdy[0]), 64'(3'b001));
    chk("full:slot_freed_cnt", 64'(ocnt[0]), 64'd3);
    advance();
    drain(0);

    // Round robin with all sources valid, then a two-cycle memory stall.
    for (int i = 0; i < 6; i++) begin
      drive(1, 3'b111, 24'h2c1b0a, 1'b1, exp_q[1].size() > 0, {$urandom, $urandom}, '1);
      settle();
      chk($sformatf("rr%0d:grant", i), 64'(req_rdy[1]), 64'(rr_order[i]));
      advance();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1, 3'b111, 24'h2c1b0a, 1'b0, exp_q[1].size() > 0, {$urandom, $urandom}, '1);
      settle();
      chk("rr_stall:dreq_val", 64'(dreq_val[1]), 64'd1);
      chk("rr_stall:dreq_addr", 64'(dreq_addr[1]), 64'h0a);
      chk("rr_stall:req_rdy", 64'(req_rdy[1]), 64'd0);
      advance();
    end
    drive(1, 3'b111, 24'h2c1b0a, 1'b1, 1'b0, '0, '1);
    settle();
    chk("rr_after_stall:grant", 64'(req_rdy[1]), 64'(3'b001));
    advance();
    drain(1);

    // Asynchronous reset with two reads in flight.
    drive(0, 3'b001, 24'h000050, 1'b1, 1'b0, '0, '1);
    tick();
    drive(0, 3'b010, 24'h005100, 1'b1, 1'b0, '0, '1);
    tick();
    idle(0);
    #2;
    chk("areset:pre_cnt", 64'(ocnt[0]), 64'd2);
    rst_n = 1'b0;
    #1;
    chk("areset:cnt", 64'(ocnt[0]), 64'd0);
    chk("areset:dresp_rdy", 64'(dresp_rdy[0]), 64'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Orphan response on an empty FIFO sets a sticky flag that only reset clears.
    drive(0, '0, '0, 1'b1, 1'b1, 64'hBAD, '1);
    settle();
    chk("orphan:dresp_rdy", 64'(dresp_rdy[0]), 64'd0);
    chk("orphan:resp_val", 64'(resp_val[0]), 64'd0);
    chk("orphan:err_before_edge", 64'(err[0]), 64'd0);
    advance();
    dresp_val[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("orphan:err_sticky", 64'(err[0]), 64'd1);
      advance();
    end
    #1 rst_n = 1'b0;
    #1 chk("orphan:err_cleared", 64'(err[0]), 64'd0);
    model_clear();
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic; requesters hold val/addr until accepted.
    for (int n = 0; n < 2; n++) idle(n);
    for (int c = 0; c < 800; c++) begin
      for (int n = 0; n < 2; n++) begin
        for (int s = 0; s < N; s++) begin
          logic held;
          held = ((req_val[n] >> s) & 3'b1) != 0 && ((last_acc[n] >> s) & 3'b1) == 0;
          if (!held) begin
            logic [N*AW-1:0] mask;
            mask = {{(N*AW-AW){1'b0}}, {AW{1'b1}}} << (s * AW);
            req_addr[n] = (req_addr[n] & ~mask) | ((N*AW)'($urandom_range(0, 255)) << (s * AW));
            if ($urandom_range(0, 1) == 1) req_val[n] = req_val[n] | (3'b001 << s);
            else                           req_val[n] = req_val[n] & ~(3'b001 << s);
          end
        end
        dreq_rdy[n]   = $urandom_range(0, 3) != 0;
        dresp_val[n]  = exp_q[n].size() > 0 && $urandom_range(0, 2) != 0;
        dresp_data[n] = {$urandom, $urandom};
        resp_rdy[n]   = N'($urandom_range(0, 7)) | N'($urandom_range(0, 7));
      end
      tick();
    end
    drain(0);
    drain(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
